// File: rtl/flatten_pkg.sv
// Shared constants and FSM state type for the flatten writer / streamer pair.
package flatten_pkg;

    localparam int BUFFER_SIZE = 225;
    localparam int DATA_W      = 22;
    localparam int IDX_W       = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_e;

endpackage

// File: rtl/flatten_streamer_if.sv
// Element stream carried from flatten_streamer to its downstream consumer.
interface flatten_streamer_if
    import flatten_pkg::*;
#(
    parameter int DATA_W = flatten_pkg::DATA_W
) ();

    logic                     o_data_valid;
    logic signed [DATA_W-1:0] o_data_out;
    logic [IDX_W-1:0]         o_index;
    logic                     o_last;
    logic                     i_ready;

    modport master (output o_data_valid, o_data_out, o_index, o_last, input  i_ready);
    modport slave  (input  o_data_valid, o_data_out, o_index, o_last, output i_ready);

endinterface

// File: rtl/flatten_streamer.sv
// Streams a parallel frame out one element per accepted handshake.
// Optional macro FLATTEN_STREAMER_SNAPSHOT_EN: stream from a copy taken on the start edge.
module flatten_streamer
    import flatten_pkg::*;
#(
    parameter int BUFFER_SIZE = flatten_pkg::BUFFER_SIZE,
    parameter int DATA_W      = flatten_pkg::DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_buffer_full,
    input  logic signed [DATA_W-1:0] i_flattened_data [BUFFER_SIZE],
    flatten_streamer_if.master       m,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_overrun
);

    // state  | meaning
    // IDLE   | waiting for a rising edge on i_buffer_full
    // STREAM | presenting elements, advancing on each accepted beat
    // DONE   | one-cycle completion pulse after the last element

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BUFFER_SIZE - 1);

    state_e                   state_q, state_d;
    logic                     full_q;
    logic                     armed_q;
    logic                     valid_q, valid_d;
    logic signed [DATA_W-1:0] data_q, data_d;
    logic [IDX_W-1:0]         index_q, index_d;
    logic                     overrun_q, overrun_d;
    logic                     start;
    logic                     accept;
    logic [IDX_W-1:0]         next_idx;
    logic signed [DATA_W-1:0] next_elem;

    // armed_q blocks a level that was already high when reset released
    assign start    = i_buffer_full & ~full_q & armed_q;
    assign accept   = valid_q & m.i_ready;
    assign next_idx = index_q + IDX_W'(1);

`ifdef FLATTEN_STREAMER_SNAPSHOT_EN
    logic signed [DATA_W-1:0] snap_q [BUFFER_SIZE];

    always_ff @(posedge clk) begin
        if (state_q == IDLE && start) begin
            snap_q <= i_flattened_data;
        end
    end

    assign next_elem = snap_q[next_idx];
`else
    assign next_elem = i_flattened_data[next_idx];
`endif

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        data_d    = data_q;
        index_d   = index_q;
        overrun_d = overrun_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = STREAM;
                    valid_d = 1'b1;
                    index_d = '0;
                    data_d  = i_flattened_data[0];
                end
            end
            STREAM: begin
                if (start) overrun_d = 1'b1;
                if (accept) begin
                    if (index_q == LAST_IDX) begin
                        valid_d = 1'b0;
                        state_d = DONE;
                    end else begin
                        index_d = next_idx;
                        data_d  = next_elem;
                    end
                end
            end
            DONE: begin
                if (start) overrun_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            full_q    <= 1'b0;
            armed_q   <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            index_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            full_q    <= i_buffer_full;
            armed_q   <= armed_q | ~i_buffer_full;
            valid_q   <= valid_d;
            data_q    <= data_d;
            index_q   <= index_d;
            overrun_q <= overrun_d;
        end
    end

    assign m.o_data_valid = valid_q;
    assign m.o_data_out   = data_q;
    assign m.o_index      = index_q;
    assign m.o_last       = valid_q & (index_q == LAST_IDX);
    assign o_busy         = (state_q != IDLE);
    assign o_done         = (state_q == DONE);
    assign o_overrun      = overrun_q;

endmodule

// File: tb/tb_flatten_streamer.sv
// Self-checking bench for flatten_streamer: directed scenarios with random frame contents and ready patterns.
`timescale 1ns/1ps
module tb_flatten_streamer;

    localparam int N     = 225;
    localparam int W     = 22;
    localparam int LASTI = N - 1;
    localparam logic signed [W-1:0] OVR = 22'sh03FFFF;

    logic clk  = 1'b0;
    logic rst  = 1'b0;
    logic full = 1'b1;
    logic signed [W-1:0] frame     [N];
    logic signed [W-1:0] exp_frame [N];
    logic busy, done, overrun;

    flatten_streamer_if #(.DATA_W(W)) s_if ();

    flatten_streamer #(.BUFFER_SIZE(N), .DATA_W(W)) dut (
        .clk              (clk),
        .rst              (rst),
        .i_buffer_full    (full),
        .i_flattened_data (frame),
        .m                (s_if),
        .o_busy           (busy),
        .o_done           (done),
        .o_overrun        (overrun)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Monitor: records accepted beats and counts handshake-rule violations.
    int                  acc_idx [$];
    logic signed [W-1:0] acc_dat [$];
    int                  stall_err = 0;
    int                  last_err  = 0;
    int                  done_err  = 0;
    logic                prev_stall   = 1'b0;
    logic                prev_lastacc = 1'b0;
    logic signed [W-1:0] prev_dat = '0;
    logic [7:0]          prev_idx = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_stall   = 1'b0;
            prev_lastacc = 1'b0;
        end else begin
            if (prev_stall && !(s_if.o_data_valid === 1'b1 && s_if.o_data_out === prev_dat &&
                                s_if.o_index === prev_idx))
                stall_err++;
            if (s_if.o_last !== (s_if.o_data_valid && int'(s_if.o_index) == LASTI)) last_err++;
            if (int'(s_if.o_index) > LASTI) last_err++;
            if (done !== prev_lastacc) done_err++;
            if (s_if.o_data_valid && s_if.i_ready) begin
                acc_idx.push_back(int'(s_if.o_index));
                acc_dat.push_back(s_if.o_data_out);
            end
            prev_stall   = s_if.o_data_valid && !s_if.i_ready;
            prev_lastacc = s_if.o_data_valid && s_if.i_ready && int'(s_if.o_index) == LASTI;
            prev_dat     = s_if.o_data_out;
            prev_idx     = s_if.o_index;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic fill_random();
        logic [31:0] r;
        for (int i = 0; i < N; i++) begin
            r        = $urandom;
            frame[i] = r[W-1:0];
        end
    endtask

    task automatic start_frame();
        full = 1'b0;
        tick(2);
        exp_frame = frame;
        acc_idx.delete();
        acc_dat.delete();
        full = 1'b1;
    endtask

    // mode: 0 ready held high, 1 pattern 1,0,0,1, 2 random.
    // hook: 1 full falls/rises at index 50, 2 overwrite element 10, 3 full low at 200 and rising in DONE.
    task automatic run_frame(input int mode, input int hook, input int max_cyc, output int cyc);
        bit toggled = 1'b0;
        bit pending = 1'b0;
        cyc = 0;
        while (cyc < max_cyc) begin
            case (mode)
                0:       s_if.i_ready = 1'b1;
                1:       s_if.i_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: s_if.i_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            cyc++;
            if (hook == 3 && done) full = 1'b1;
            if (done) break;
            if (hook == 1) begin
                if (pending) begin
                    full    = 1'b1;
                    pending = 1'b0;
                end else if (!toggled && s_if.o_data_valid && s_if.o_index == 8'd50) begin
                    full    = 1'b0;
                    toggled = 1'b1;
                    pending = 1'b1;
                end
            end
            if (hook == 2 && cyc == 1) begin
                frame[10] = OVR;
`ifndef FLATTEN_STREAMER_SNAPSHOT_EN
                exp_frame[10] = OVR;
`endif
            end
            if (hook == 3 && s_if.o_data_valid && s_if.o_index == 8'd200) full = 1'b0;
        end
        chk("done_seen", done, 1);
        s_if.i_ready = 1'b0;
    endtask

    task automatic check_frame(input string name);
        chk({name, "_beats"}, acc_dat.size(), N);
        for (int i = 0; i < N && i < acc_dat.size(); i++) begin
            chk($sformatf("%s_idx[%0d]", name, i), acc_idx[i], i);
            chk($sformatf("%s_data[%0d]", name, i), acc_dat[i], exp_frame[i]);
        end
    endtask

    task automatic wait_index(input int target, input int max_cyc);
        int c = 0;
        s_if.i_ready = 1'b1;
        while (!(s_if.o_data_valid && int'(s_if.o_index) == target) && c < max_cyc) begin
            @(negedge clk);
            c++;
        end
        chk("reach_index", s_if.o_index, target);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_valid"},   s_if.o_data_valid, 0);
        chk({name, "_data"},    s_if.o_data_out,   0);
        chk({name, "_index"},   s_if.o_index,      0);
        chk({name, "_last"},    s_if.o_last,       0);
        chk({name, "_busy"},    busy,              0);
        chk({name, "_done"},    done,              0);
        chk({name, "_overrun"}, overrun,           0);
    endtask

    initial begin
        int cyc;
        s_if.i_ready = 1'b0;
        for (int i = 0; i < N; i++) frame[i] = W'(i - 112);

        // Reset with full already high; release must not start a frame.
        tick(3);
        chk_all_zero("reset");
        rst = 1'b1;
        tick(5);
        chk("no_start_valid", s_if.o_data_valid, 0);
        chk("no_start_busy",  busy,              0);

        // Ramp frame i-112: one-cycle latency, then 225 back-to-back beats.
        start_frame();
        tick(1);
        chk("first_valid", s_if.o_data_valid, 1);
        chk("first_index", s_if.o_index,      0);
        chk("first_data",  s_if.o_data_out,   exp_frame[0]);
        chk("first_busy",  busy,              1);
        tick(1);
        chk("hold_valid",  s_if.o_data_valid, 1);
        chk("hold_data",   s_if.o_data_out,   exp_frame[0]);
        run_frame(0, 0, 400, cyc);
        chk("stream_cycles", cyc, N);
        check_frame("ramp");
        chk("ramp_overrun", overrun, 0);
        tick(1);
        chk("post_done", done, 0);
        chk("post_busy", busy, 0);

        // Extreme values at both ends, ready pattern 1,0,0,1.
        fill_random();
        frame[0]     = 22'sh200000;
        frame[LASTI] = 22'sh1FFFFF;
        start_frame();
        run_frame(1, 0, 2000, cyc);
        check_frame("extreme");

        // Random data, random ready, full falls and rises again at index 50.
        fill_random();
        start_frame();
        run_frame(2, 1, 2000, cyc);
        check_frame("retrig");
        chk("overrun_set", overrun, 1);
        tick(3);
        chk("overrun_sticky", overrun, 1);
        rst = 1'b0;
        tick(1);
        chk("overrun_cleared", overrun, 0);
        rst = 1'b1;
        tick(2);

        // Reset at index 100 with full held high: no restart until full toggles.
        fill_random();
        start_frame();
        wait_index(100, 400);
        rst = 1'b0;
        #1;
        chk_all_zero("midrst");
        tick(1);
        chk_all_zero("midrst_next");
        rst = 1'b1;
        tick(10);
        chk("midrst_idle_valid", s_if.o_data_valid, 0);
        chk("midrst_idle_busy",  busy,              0);
        fill_random();
        start_frame();
        run_frame(0, 0, 400, cyc);
        check_frame("restart");

        // Start edge landing in the DONE cycle is ignored but flagged.
        fill_random();
        start_frame();
        run_frame(0, 3, 400, cyc);
        check_frame("doneedge");
        tick(1);
        chk("doneedge_busy",    busy,              0);
        chk("doneedge_overrun", overrun,           1);
        tick(4);
        chk("doneedge_valid",   s_if.o_data_valid, 0);
        chk("doneedge_idle",    busy,              0);
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        tick(2);

        // Writer overwrites element 10 after the start edge.
        fill_random();
        frame[10] = -22'sd5;
        start_frame();
        run_frame(0, 2, 400, cyc);
        check_frame("overwrite");

        tick(2);
        chk("stall_stability", stall_err, 0);
        chk("last_flag",       last_err,  0);
        chk("done_pulse",      done_err,  0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
